// File: rtl/fifo_drain_sched_if.sv
// Bundle between the round-robin drain scheduler, its bank of FWFT fifos
// and the single downstream consumer. The master side is the scheduler.
interface fifo_drain_sched_if #(
  parameter int WIDTH = 8,
  parameter int NUM_Q = 4,
  parameter int IDWID = $clog2(NUM_Q)
);
  logic [NUM_Q-1:0]       q_empty;
  logic [NUM_Q*WIDTH-1:0] q_data;
  logic [NUM_Q-1:0]       q_pop;
  logic [NUM_Q-1:0]       q_mask;
  logic                   out_ready;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_data;
  logic [IDWID-1:0]       out_id;
  logic                   out_last;
  logic                   busy;

  modport master (
    input  q_empty, q_data, q_mask, out_ready,
    output q_pop, out_valid, out_data, out_id, out_last, busy
  );

  modport slave (
    output q_empty, q_data, q_mask, out_ready,
    input  q_pop, out_valid, out_data, out_id, out_last, busy
  );
endinterface

// File: rtl/fifo_drain_sched.sv
// Round-robin drain scheduler: grants one eligible FWFT queue at a time,
// passes its head straight to the output and pops it on each accepted beat.
// A grant ends after QUANTUM beats or as soon as the queue stops being
// eligible; the search for the next grant starts just after the last one.
module fifo_drain_sched #(
  parameter int WIDTH   = 8,
  parameter int NUM_Q   = 4,
  parameter int QUANTUM = 4,
  parameter int IDWID   = $clog2(NUM_Q)
) (
  input  logic               clk,
  input  logic               rst,
  fifo_drain_sched_if.master bus
);

  localparam int              CW        = $clog2(QUANTUM) + 1;
  localparam logic [CW-1:0]    LAST_BEAT = CW'(QUANTUM - 1);
  localparam logic [IDWID-1:0] LAST_Q    = IDWID'(NUM_Q - 1);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDWID-1:0] r_grant, w_grant_nxt;
  logic [IDWID-1:0] r_last,  w_last_nxt;
  logic [CW-1:0]    r_cnt,   w_cnt_nxt;

  logic [NUM_Q-1:0] w_elig;
  logic [NUM_Q-1:0] w_pop;
  logic [WIDTH-1:0] w_data;
  logic [IDWID-1:0] w_pick;
  logic             w_any;
  logic             w_serve;
  logic             w_valid;
  logic             w_fire;
  logic             w_at_last;

  assign w_elig    = bus.q_mask & ~bus.q_empty;
  assign w_serve   = (r_state == SERVE);
  assign w_valid   = w_serve & w_elig[r_grant];
  assign w_fire    = w_valid & bus.out_ready;
  assign w_at_last = (r_cnt == LAST_BEAT);

  // Rotating-priority search: first eligible queue after r_last, wrapping.
  // Walking the offsets from farthest to nearest lets the nearest win.
  always_comb begin
    logic [IDWID-1:0] idx;
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    w_any  = 1'b0;
    w_pick = '0;
    idx    = '0;
    for (int k = NUM_Q; k >= 1; k--) begin
      idx = IDWID'((int'(r_last) + k) % NUM_Q);
      if (w_elig[idx]) begin
        w_any  = 1'b1;
        w_pick = idx;
      end
    end
  end

  // Head-of-queue mux for the granted queue (zero-latency pass-through).
  always_comb begin
    w_data = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      if (r_grant == IDWID'(i)) w_data = bus.q_data[i*WIDTH +: WIDTH];
    end
  end

  // Pop strobe only to the granted queue, only on an accepted beat.
  always_comb begin
    w_pop = '0;
    if (!rst && w_fire) w_pop[r_grant] = 1'b1;
  end

  assign bus.q_pop     = w_pop;
  assign bus.out_valid = !rst && w_valid;
  assign bus.out_last  = !rst && w_valid && w_at_last;
  assign bus.busy      = !rst && w_serve;
  assign bus.out_id    = rst ? '0 : r_grant;
  assign bus.out_data  = w_data;

  // Next-state: grant on any eligibility, end the grant on quantum or drain.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant_nxt = w_pick;
          w_cnt_nxt   = '0;
          w_state_nxt = SERVE;
        end
      end
      SERVE: begin
        if (!w_elig[r_grant]) begin
          // Drained or masked off: forfeit the rest of the quantum.
          w_last_nxt  = r_grant;
          w_state_nxt = IDLE;
        end else if (w_fire) begin
          if (w_at_last) begin
            w_last_nxt  = r_grant;
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        // Stalled beat (valid, not ready): hold everything.
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register; synchronous reset dominates every other input.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= LAST_Q;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule
